// File: rtl/decrypt_iter_if.sv
// ---------------------------------------------------------------------------
// decrypt_iter_if -- request/acknowledge bundle for the iterative decryptor.
//
// Signals
//   req   requester -> block  4-phase request, held until ack is seen
//   k     requester -> block  cipher key (N_K bits), sampled on accept
//   c     requester -> block  ciphertext (N_B bits), sampled on accept
//   ack   block -> requester  high while m carries a valid result
//   m     block -> requester  recovered plaintext (N_B bits)
//   busy  block -> requester  high while rounds are being applied
//
// Modports: master drives req/k/c, slave drives ack/m/busy.
// ---------------------------------------------------------------------------
`ifndef N_K
`define N_K 64
`endif
`ifndef N_B
`define N_B 32
`endif
`ifndef N_R
`define N_R 8
`endif

interface decrypt_iter_if #(
    parameter int N_K = `N_K,
    parameter int N_B = `N_B
);
    logic           req;
    logic [N_K-1:0] k;
    logic [N_B-1:0] c;
    logic           ack;
    logic [N_B-1:0] m;
    logic           busy;

    modport master (output req, output k, output c, input ack, input m, input busy);
    modport slave  (input req, input k, input c, output ack, output m, output busy);
endinterface

// File: rtl/decrypt_iter.sv
// ---------------------------------------------------------------------------
// decrypt_iter -- iterative inverse of the team block cipher (encrypt_comb).
//
// Cipher being inverted (encrypt_comb):
//   x ^= rk(N_R)                        input whitening
//   for r = 0 .. N_R-1: x = round(x, rk(r))
//   x ^= rk(N_R+1)                      output whitening
//   round(x, rk): a = x + rk; b = rotl(a, 5); return b ^ (b >> N_B/2)
//
// This block undoes the output whitening on the first RUN edge, then applies
// one inverse round per edge for r = N_R-1 down to 0, and on the edge that
// consumes r = 0 it also strips the input whitening and writes m.  Total
// latency from the accept edge to ack is therefore N_R+1 edges.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   decrypt_iter_if.slave (req, k, c in; ack, m, busy out)
//
// All outputs come straight from flops; nothing on bus is combinationally
// routed to an output.
// ---------------------------------------------------------------------------
`ifndef N_K
`define N_K 64
`endif
`ifndef N_B
`define N_B 32
`endif
`ifndef N_R
`define N_R 8
`endif

module decrypt_iter #(
    parameter int N_K = `N_K,
    parameter int N_B = `N_B,
    parameter int N_R = `N_R
) (
    input  logic          clk,
    input  logic          rst,
    decrypt_iter_if.slave bus
);

    localparam int RW   = $clog2(N_R + 1);
    localparam int HALF = N_B / 2;
    localparam int ROT  = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [RW-1:0] R_LAST = RW'(N_R - 1);
    localparam logic [RW-1:0] R_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    // Key schedule shared with encrypt_comb. Indices 0..N_R-1 are round keys,
    // N_R is the input-whitening key, N_R+1 the output-whitening key.
    // The key is rotated by 7*idx, folded down to N_B bits by XOR, and a
    // golden-ratio round constant keeps the keys distinct for a zero key.
    function automatic logic [N_B-1:0] round_key(input logic [N_K-1:0] key,
                                                 input int             idx);
        logic [N_K-1:0] rot;
        logic [N_B-1:0] acc;
        logic [31:0]    rc;
        int             sh;
        sh  = (idx * 7) % N_K;
        rot = (key << sh) | (key >> (N_K - sh));
        acc = {N_B{1'b0}};
        for (int j = 0; j < N_K; j++) begin
            acc[j % N_B] = acc[j % N_B] ^ rot[j];
        end
        rc  = 32'h9E37_79B9 * 32'(idx + 1);
        return acc ^ N_B'(rc);
    endfunction

    // Inverse of one forward round. The xorshift by N_B/2 is its own inverse
    // because the second shift pushes everything out of the word.
    function automatic logic [N_B-1:0] inv_round(input logic [N_B-1:0] x,
                                                 input logic [N_B-1:0] rk);
        logic [N_B-1:0] b;
        logic [N_B-1:0] a;
        b = x ^ (x >> HALF);
        a = {b[ROT-1:0], b[N_B-1:ROT]};
        return a - rk;
    endfunction

    logic [1:0]     fsm_r;
    logic [N_B-1:0] blk_r;
    logic [N_K-1:0] key_r;
    logic [RW-1:0]  rnd_r;
    logic           whiten_r;   // first RUN edge still has to strip output whitening
    logic [N_B-1:0] m_r;
    logic           ack_r;
    logic           busy_r;

    logic [N_B-1:0] rk_s;
    logic [N_B-1:0] wk_in_s;
    logic [N_B-1:0] step_s;

    // Next value of the block register for the current RUN step.
    always_comb begin
        rk_s    = round_key(key_r, whiten_r ? (N_R + 1) : int'(rnd_r));
        wk_in_s = round_key(key_r, N_R);
        if (whiten_r) begin
            step_s = blk_r ^ rk_s;
        end else begin
            step_s = inv_round(blk_r, rk_s);
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r    <= S_IDLE;
            blk_r    <= {N_B{1'b0}};
            key_r    <= {N_K{1'b0}};
            rnd_r    <= R_ZERO;
            whiten_r <= 1'b0;
            m_r      <= {N_B{1'b0}};
            ack_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (fsm_r)
                S_IDLE: begin
                    if (bus.req) begin
                        fsm_r    <= S_RUN;
                        blk_r    <= bus.c;
                        key_r    <= bus.k;
                        rnd_r    <= R_LAST;
                        whiten_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Inputs are deliberately not looked at here.
                    blk_r <= step_s;
                    if (whiten_r) begin
                        whiten_r <= 1'b0;
                    end else if (rnd_r == R_ZERO) begin
                        m_r    <= step_s ^ wk_in_s;
                        fsm_r  <= S_DONE;
                        ack_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        rnd_r <= rnd_r - R_ONE;
                    end
                end
                S_DONE: begin
                    if (!bus.req) begin
                        fsm_r <= S_IDLE;
                        ack_r <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle.
                    fsm_r    <= S_IDLE;
                    rnd_r    <= R_ZERO;
                    whiten_r <= 1'b0;
                    ack_r    <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack  = ack_r;
    assign bus.m    = m_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_decrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_decrypt_iter -- self-checking bench for decrypt_iter.
// Expected plaintexts come from the bench's own cipher model: ciphertexts are
// produced by encrypting a known plaintext, so the DUT must return it.
// ---------------------------------------------------------------------------
module tb_decrypt_iter;

    localparam int NK  = 64;
    localparam int NB  = 32;
    localparam int NR  = 8;
    localparam int LAT = NR + 1;
    localparam int LIM = 4 * NR + 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    decrypt_iter_if #(.N_K(NK), .N_B(NB)) bus();

    decrypt_iter #(.N_K(NK), .N_B(NB), .N_R(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference cipher model ----------------
    function automatic logic [31:0] rotl32(input logic [31:0] a, input int s);
        logic [63:0] t;
        t = {a, a} << s;
        return t[63:32];
    endfunction

    function automatic logic [31:0] m_rk(input logic [63:0] key, input int i);
        logic [127:0] kk;
        logic [63:0]  r;
        kk = {key, key} << ((i * 7) % 64);
        r  = kk[127:64];
        return r[31:0] ^ r[63:32] ^ (32'h9E3779B9 * (i + 1));
    endfunction

    function automatic logic [31:0] m_encrypt(input logic [63:0] key, input logic [31:0] p);
        logic [31:0] x, b;
        x = p ^ m_rk(key, NR);
        for (int r = 0; r < NR; r++) begin
            b = rotl32(x + m_rk(key, r), 5);
            x = b ^ (b >> 16);
        end
        return x ^ m_rk(key, NR + 1);
    endfunction

    function automatic logic [31:0] m_decrypt(input logic [63:0] key, input logic [31:0] c);
        logic [31:0] x, b;
        x = c ^ m_rk(key, NR + 1);
        for (int r = NR - 1; r >= 0; r--) begin
            b = x ^ (x >> 16);
            x = rotl32(b, 27) - m_rk(key, r);
        end
        return x ^ m_rk(key, NR);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Caller is at a negedge; raises req and returns just after the accept edge.
    task automatic start(input logic [63:0] kk, input logic [31:0] cc);
        bus.req = 1'b1;
        bus.k   = kk;
        bus.c   = cc;
        @(posedge clk);
    endtask

    // Caller is at a negedge after the accept edge; counts edges until ack.
    task automatic wait_ack(output int lat);
        lat = 0;
        while (bus.ack !== 1'b1 && lat < LIM) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Caller is at the negedge where ack was seen; ends at the negedge after ack falls.
    task automatic finish_txn(input string name);
        bus.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_ack_fall"}, 64'(bus.ack), 64'd0);
    endtask

    task automatic txn(input string name, input logic [63:0] kk, input logic [31:0] cc,
                       input logic [31:0] exp);
        int lat;
        start(kk, cc);
        @(negedge clk);
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        wait_ack(lat);
        check({name, "_lat"}, 64'(lat), 64'(LAT));
        check({name, "_m"}, 64'(bus.m), 64'(exp));
        finish_txn(name);
    endtask

    typedef struct {
        logic [63:0] k;
        logic [31:0] x;
    } vec_t;

    vec_t vt[8];

    initial begin
        int          lat;
        int          acks;
        int          t0;
        logic [63:0] kk;
        logic [31:0] xx, cc;

        vt[0] = '{k: 64'h0, x: 32'h0};
        vt[1] = '{k: 64'hFFFF_FFFF_FFFF_FFFF, x: 32'hFFFF_FFFF};
        vt[2] = '{k: 64'h0, x: 32'hFFFF_FFFF};
        vt[3] = '{k: 64'hFFFF_FFFF_FFFF_FFFF, x: 32'h0};
        vt[4] = '{k: 64'h0123_4567_89AB_CDEF, x: 32'hDEAD_BEEF};
        vt[5] = '{k: 64'h8000_0000_0000_0001, x: 32'h0000_0001};
        vt[6] = '{k: 64'h0000_0000_0000_0001, x: 32'h8000_0000};
        vt[7] = '{k: 64'hFEDC_BA98_7654_3210, x: 32'h1234_5678};

        // Reset overrides a pending request.
        rst     = 1'b1;
        bus.req = 1'b1;
        bus.k   = 64'hA5A5_A5A5_A5A5_A5A5;
        bus.c   = 32'h5A5A_5A5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_m", 64'(bus.m), 64'd0);

        // Release reset with req still high: the next edge accepts.
        rst = 1'b0;
        txn("post_rst", vt[4].k, m_encrypt(vt[4].k, vt[4].x), vt[4].x);

        // Vector table, includes all-zero and all-one round trips.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            txn($sformatf("vec%0d", i), vt[i].k, m_encrypt(vt[i].k, vt[i].x), vt[i].x);
        end

        // Random round trips and random ciphertexts.
        for (int i = 0; i < 10; i++) begin
            kk = {$urandom, $urandom};
            xx = $urandom;
            @(negedge clk);
            txn($sformatf("rt%0d", i), kk, m_encrypt(kk, xx), xx);
            kk = {$urandom, $urandom};
            cc = $urandom;
            @(negedge clk);
            txn($sformatf("rc%0d", i), kk, cc, m_decrypt(kk, cc));
        end

        // Input churn during RUN, including req dropping.
        kk = {$urandom, $urandom};
        xx = $urandom;
        @(negedge clk);
        start(kk, m_encrypt(kk, xx));
        for (int i = 0; i <= NR; i++) begin
            @(negedge clk);
            check("churn_run", {62'd0, bus.ack, bus.busy}, 64'd1);
            bus.k   = {$urandom, $urandom};
            bus.c   = $urandom;
            bus.req = (i == NR) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("churn_ack", 64'(bus.ack), 64'd1);
        check("churn_m", 64'(bus.m), 64'(xx));
        finish_txn("churn");

        // Req held high for 10 cycles after ack: stay in DONE, no new accept.
        kk = {$urandom, $urandom};
        xx = $urandom | 32'h1;
        @(negedge clk);
        start(kk, m_encrypt(kk, xx));
        @(negedge clk);
        wait_ack(lat);
        check("hold_lat", 64'(lat), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            bus.k = {$urandom, $urandom};
            bus.c = $urandom;
            @(negedge clk);
            check("hold_flags", {62'd0, bus.ack, bus.busy}, 64'd2);
            check("hold_m", 64'(bus.m), 64'(xx));
        end
        finish_txn("hold");
        // New request raised right after ack falls is accepted on the next edge.
        txn("hold_next", vt[7].k, m_encrypt(vt[7].k, vt[7].x), vt[7].x);

        // Reset two edges after accept abandons the operation.
        kk = {$urandom, $urandom};
        xx = $urandom;
        @(negedge clk);
        start(kk, m_encrypt(kk, xx));
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ack", 64'(bus.ack), 64'd0);
        check("mid_rst_m", 64'(bus.m), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        acks = 0;
        for (int i = 0; i < 2 * NR; i++) begin
            @(negedge clk);
            if (bus.ack !== 1'b0 || bus.busy !== 1'b0) acks++;
        end
        check("mid_rst_quiet", 64'(acks), 64'd0);
        @(negedge clk);
        txn("after_rst", kk, m_encrypt(kk, xx), xx);

        // Back-to-back: 16 transactions at the minimum period.
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            kk = {$urandom, $urandom};
            xx = $urandom;
            txn($sformatf("b2b%0d", i), kk, m_encrypt(kk, xx), xx);
        end
        check("b2b_total", 64'(cyc - t0), 64'(16 * (NR + 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decrypt_iter.md
DECRYPT_ITER -- requirements
Module: decrypt_iter

Interface
REQ-001 Parameter N_K, default `N_K (params.h), cipher key width in bits.
REQ-002 Parameter N_B, default `N_B (params.h), block width in bits.
REQ-003 Parameter N_R, default `N_R (params.h), number of cipher rounds, at least 1.
REQ-004 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 req  input  1  request; SHALL be held high until ack is seen, then dropped (4-phase).
REQ-007 k  input  N_K  cipher key; sampled only on the accept edge.
REQ-008 c  input  N_B  ciphertext; sampled only on the accept edge.
REQ-009 ack  output  1  acknowledge; high while m is valid.
REQ-010 m  output  N_B  recovered plaintext; registered output.
REQ-011 busy  output  1  high while in RUN.

Function
REQ-012 Block SHALL compute the exact inverse of encrypt_comb: for all k and x, decrypt_iter(k, encrypt_comb(k, x)) = x.
REQ-013 Datapath SHALL be iterative: one inverse round per clock, using the team round-inverse function and key schedule shared with encrypt_comb.
REQ-014 Inverse rounds SHALL run in order r = N_R-1 down to 0; round counter is ceil(log2(N_R+1)) bits and never wraps.
REQ-015 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-016 IDLE -> RUN on a rising edge with req=1; this is the accept edge. On it: state reg <= c, key reg <= k, r <= N_R-1.
REQ-017 RUN: each edge applies one inverse round with round key r, then decrements r; when r=0 is consumed, apply the final key step, m <= result, go to DONE.
REQ-018 Latency: ack SHALL rise exactly N_R+1 edges after the accept edge.
REQ-019 DONE: ack=1 and m is held stable; DONE -> IDLE on the first edge with req=0; ack falls on that edge.
REQ-020 While req stays high in DONE, the block SHALL stay in DONE with no new accept.
REQ-021 Changes on k, c or req during RUN SHALL be ignored; req=0 during RUN SHALL NOT abort.
REQ-022 m SHALL keep the last result after returning to IDLE, until the next result is written in DONE.
REQ-023 A new accept SHALL need req low for at least one edge after DONE; minimum period is N_R+3 cycles.
REQ-024 busy=1 exactly in RUN; ack=1 exactly in DONE; there are no combinational paths from inputs to outputs.

Reset
REQ-025 rst=1 on an edge SHALL force IDLE, ack=0, busy=0, m=0, r=0, state and key regs=0, overriding all other inputs.
REQ-026 rst asserted during RUN or DONE SHALL abandon the operation; no ack for it SHALL ever appear.
REQ-027 After rst deasserts with req=1, the next edge SHALL be treated as an accept edge.

Verification
REQ-028 Vector sweep: for i = 0..`N_V-1, set k=v_k[i], c=v_c[i], pulse req -> ack after N_R+1 cycles with m === v_m[i], pass for all i.
REQ-029 Round trip: drive encrypt_comb with k=0, m=0 and feed its c with k=0 -> m=0; repeat with all-ones k and m -> m all-ones.
REQ-030 Input churn: after the accept edge, randomise k and c every cycle during RUN -> m equals the decryption of the values sampled at accept.
REQ-031 Req held high for 10 cycles after ack -> ack stays 1, m stable, busy 0; drop req -> ack=0 next edge, a new req is accepted one edge later.
REQ-032 Reset mid-RUN: accept, then rst high for 1 cycle at accept+2 -> ack=0, m=0, busy=0, no ack for 2N_R cycles with req low; the next transaction passes.
REQ-033 Back-to-back: 16 transactions with req re-raised the cycle after ack falls -> each completes in N_R+1 cycles; total equals 16(N_R+3) cycles, within 1 cycle.
